// File: rtl/drum_acc.sv
// drum_acc: saturating signed frame accumulator for the DRUM product stream.
// Products arrive on a valid/ready input and each frame's sum is returned on a second valid/ready output.
module drum_acc #(
  parameter int PROD_W = 16,
  parameter int ACC_W  = 24,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic [CNT_W-1:0]  cfg_len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_acc,
  output logic [CNT_W-1:0]  out_cnt,
  output logic              out_sat
);
  typedef enum logic {ACC, HOLD} state_t;
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d, oacc_q, oacc_d, acc_nx;
  logic [CNT_W-1:0]   cnt_q, cnt_d, ocnt_q, ocnt_d, cnt_inc;
  logic               sat_q, sat_d, osat_q, osat_d;
  logic [ACC_W:0]     sum;
  logic               fire, ovf, frame_end;
  always_comb begin
    fire      = in_valid & (state_q == ACC);
    sum       = {acc_q[ACC_W-1], acc_q} + {{(ACC_W+1-PROD_W){in_prod[PROD_W-1]}}, in_prod};
    // Overflow of the ACC_W range shows up as disagreeing top two bits of the widened sum.
    ovf       = sum[ACC_W] ^ sum[ACC_W-1];
    acc_nx    = ovf ? (sum[ACC_W] ? ACC_MIN : ACC_MAX) : sum[ACC_W-1:0];
    cnt_inc   = cnt_q + 1'b1;
    frame_end = in_last | ((cfg_len != '0) && (cnt_inc == cfg_len));
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    sat_d     = sat_q;
    oacc_d    = oacc_q;
    ocnt_d    = ocnt_q;
    osat_d    = osat_q;
    if (clr) begin
      state_d = ACC;
      acc_d   = '0;
      cnt_d   = '0;
      sat_d   = 1'b0;
    end else if (fire) begin
      acc_d = acc_nx;
      cnt_d = cnt_inc;
      sat_d = sat_q | ovf;
      if (frame_end) begin
        state_d = HOLD;
        oacc_d  = acc_nx;
        ocnt_d  = cnt_inc;
        osat_d  = sat_q | ovf;
      end
    end else if (state_q == HOLD && out_ready) begin
      state_d = ACC;
      acc_d   = '0;
      cnt_d   = '0;
      sat_d   = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACC;
      acc_q   <= '0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
      oacc_q  <= '0;
      ocnt_q  <= '0;
      osat_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
      oacc_q  <= oacc_d;
      ocnt_q  <= ocnt_d;
      osat_q  <= osat_d;
    end
  end
  assign in_ready  = (state_q == ACC);
  assign out_valid = (state_q == HOLD);
  assign out_acc   = oacc_q;
  assign out_cnt   = ocnt_q;
  assign out_sat   = osat_q;
endmodule

// File: tb/tb_drum_acc.sv
// tb_drum_acc: directed and randomized frames for drum_acc, checked against an arithmetic frame model.
module tb_drum_acc;
  logic        clk = 0, rst_n = 0, clr = 0;
  logic [7:0]  cfg_len = 0;
  logic        in_valid = 0, in_last = 0, out_ready = 0;
  logic [15:0] in_prod = 0;
  logic        in_ready, out_valid, out_sat;
  logic [23:0] out_acc;
  logic [7:0]  out_cnt;
  int tests = 0, fails = 0;
  longint m_acc = 0;
  int     m_cnt = 0;
  bit     m_sat = 0;
  drum_acc dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .cfg_len(cfg_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_prod(in_prod), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_acc(out_acc), .out_cnt(out_cnt), .out_sat(out_sat)
  );
  always #5 clk = ~clk;
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string tag, input longint got, input longint exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic bit model_beat(input int p, input bit last);
    longint s;
    bit fe;
    fe = last || (cfg_len != 0 && ((m_cnt + 1) % 256) == cfg_len);
    s = m_acc + p;
    if (s > 8388607) begin m_acc = 8388607; m_sat = 1; end
    else if (s < -8388608) begin m_acc = -8388608; m_sat = 1; end
    else m_acc = s;
    m_cnt = (m_cnt + 1) % 256;
    return fe;
  endfunction
  function automatic void model_clear();
    m_acc = 0; m_cnt = 0; m_sat = 0;
  endfunction
  task automatic send(input int p, input bit last, output bit fe);
    chk("in_ready_before_beat", in_ready, 1);
    in_prod = p[15:0]; in_last = last; in_valid = 1;
    fe = model_beat($signed(p[15:0]), last);
    @(posedge clk); #1;
    in_valid = 0; in_last = 0;
  endtask
  task automatic check_result(input string tag);
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_ready"}, in_ready, 0);
    chk({tag, "_acc"}, $signed(out_acc), m_acc);
    chk({tag, "_cnt"}, out_cnt, m_cnt);
    chk({tag, "_sat"}, out_sat, m_sat);
  endtask
  task automatic handshake();
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    chk("after_hs_valid", out_valid, 0);
    chk("after_hs_ready", in_ready, 1);
    model_clear();
  endtask
  initial begin
    bit fe;
    int nb, p, r;
    longint keep_acc;
    #2;
    chk("rst_valid", out_valid, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_acc", out_acc, 0);
    chk("rst_cnt", out_cnt, 0);
    chk("rst_sat", out_sat, 0);
    #10 rst_n = 1;
    @(posedge clk); #1;
    // basic frame, back-to-back, out_ready held high
    cfg_len = 3; out_ready = 1;
    send(100, 0, fe); send(-30, 0, fe); send(7, 0, fe);
    chk("basic_fe", fe, 1);
    chk("basic_valid", out_valid, 1);
    chk("basic_ready", in_ready, 0);
    chk("basic_acc", $signed(out_acc), 77);
    chk("basic_cnt", out_cnt, 3);
    chk("basic_sat", out_sat, 0);
    @(posedge clk); #1;
    out_ready = 0;
    chk("basic_ready_back", in_ready, 1);
    chk("basic_valid_drop", out_valid, 0);
    chk("basic_keep_acc", $signed(out_acc), 77);
    model_clear();
    // in_last frame, then stall in HOLD with beats offered
    cfg_len = 0;
    send(16'h7FFF, 0, fe); send(1, 1, fe);
    chk("last_acc_exp", m_acc, 32768);
    check_result("last");
    for (int i = 0; i < 5; i++) begin
      in_valid = 1; in_prod = 16'h1234; in_last = i[0];
      @(posedge clk); #1;
      check_result("hold_stable");
    end
    in_valid = 0;
    handshake();
    send(-5, 0, fe); send(5, 1, fe);
    check_result("after_hold");
    chk("after_hold_acc0", $signed(out_acc), 0);
    handshake();
    // positive saturation with count wrap
    for (int i = 0; i < 300; i++) send(16'h7FFF, i == 299, fe);
    chk("psat_acc", $signed(out_acc), 8388607);
    chk("psat_cnt", out_cnt, 44);
    chk("psat_sat", out_sat, 1);
    check_result("psat");
    handshake();
    send(-5, 0, fe); send(5, 1, fe);
    chk("post_sat_acc", $signed(out_acc), 0);
    chk("post_sat_sat", out_sat, 0);
    handshake();
    // negative saturation
    for (int i = 0; i < 260; i++) send(16'h8000, i == 259, fe);
    chk("nsat_acc", $signed(out_acc), -8388608);
    chk("nsat_sat", out_sat, 1);
    check_result("nsat");
    handshake();
    // in_last coinciding with the length match ends one frame
    cfg_len = 2;
    send(4, 0, fe); send(6, 1, fe);
    check_result("last_and_len");
    handshake();
    chk("single_end_valid", out_valid, 0);
    // clr beats a simultaneous input beat
    cfg_len = 0;
    send(10, 0, fe); send(20, 0, fe);
    clr = 1; in_valid = 1; in_prod = 99;
    @(posedge clk); #1;
    clr = 0; in_valid = 0;
    model_clear();
    chk("clr_ready", in_ready, 1);
    chk("clr_valid", out_valid, 0);
    cfg_len = 2;
    send(1, 0, fe); send(2, 0, fe);
    chk("clr_acc", $signed(out_acc), 3);
    check_result("clr_next");
    // clr beats a simultaneous result handshake in HOLD
    clr = 1; out_ready = 1;
    @(posedge clk); #1;
    clr = 0; out_ready = 0;
    model_clear();
    chk("clr_hold_valid", out_valid, 0);
    chk("clr_hold_keep", $signed(out_acc), 3);
    // randomized frames with idle gaps, cfg_len changes and stalls
    for (int f = 0; f < 40; f++) begin
      cfg_len = $urandom_range(0, 5);
      nb = 0; fe = 0;
      while (!fe) begin
        if ($urandom_range(0, 3) == 0) begin
          in_prod = $urandom; in_last = $urandom_range(0, 1);
          @(posedge clk); #1;
          in_last = 0;
        end
        if ($urandom_range(0, 7) == 0) cfg_len = $urandom_range(0, 5);
        r = $urandom_range(0, 9);
        p = r == 0 ? 32767 : r == 1 ? -32768 : $signed(16'($urandom));
        send(p, (cfg_len == 0 && $urandom_range(0, 3) == 0) || nb >= 7, fe);
        nb++;
      end
      check_result("rand");
      keep_acc = m_acc;
      r = $urandom_range(0, 3);
      for (int i = 0; i < r; i++) begin
        in_valid = 1; in_prod = $urandom;
        @(posedge clk); #1;
        chk("rand_stall_acc", $signed(out_acc), keep_acc);
      end
      in_valid = 0;
      handshake();
    end
    // asynchronous reset while holding a result
    cfg_len = 1;
    send(500, 0, fe);
    check_result("pre_rst");
    #2 rst_n = 0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_ready", in_ready, 1);
    chk("arst_acc", out_acc, 0);
    chk("arst_cnt", out_cnt, 0);
    chk("arst_sat", out_sat, 0);
    #10 rst_n = 1;
    model_clear();
    @(posedge clk); #1;
    send(-7, 1, fe);
    check_result("post_rst");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
